// File: rtl/cmos_serial_adder.sv
// Bit-serial adder: one switch-level CMOS full-adder slice (nine NAND2 cells) walked over
// WIDTH bits LSB first. Optional macro CMOS_SERIAL_ADDER_SUB_EN adds a subtract mode (a + ~b + 1).

module cmos_nand2 (
  output wire y,
  input  wire a,
  input  wire b
);
  supply1 vdd;
  supply0 gnd;
  wire    mid;

  // Parallel pull-up, series pull-down.
  pmos p0 (y, vdd, a);
  pmos p1 (y, vdd, b);
  nmos n0 (y, mid, a);
  nmos n1 (mid, gnd, b);
endmodule

module cmos_fa_slice (
  input  wire a,
  input  wire b,
  input  wire c,
  output wire s,
  output wire co
);
  wire n1, n2, n3, n4, n5, n6, n7;

  // n4 = a ^ b; s = n4 ^ c; co shares n1/n5 with the XOR trees.
  cmos_nand2 u1 (.y(n1), .a(a),  .b(b));
  cmos_nand2 u2 (.y(n2), .a(a),  .b(n1));
  cmos_nand2 u3 (.y(n3), .a(b),  .b(n1));
  cmos_nand2 u4 (.y(n4), .a(n2), .b(n3));
  cmos_nand2 u5 (.y(n5), .a(n4), .b(c));
  cmos_nand2 u6 (.y(n6), .a(n4), .b(n5));
  cmos_nand2 u7 (.y(n7), .a(c),  .b(n5));
  cmos_nand2 u8 (.y(s),  .a(n6), .b(n7));
  cmos_nand2 u9 (.y(co), .a(n5), .b(n1));
endmodule

module cmos_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CMOS_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               load;
  logic               last_bit;
  logic               b_bit;
  wire                s_bit, c_bit;

`ifdef CMOS_SERIAL_ADDER_SUB_EN
  logic sub_q;
  wire  b_inv;

  cmos_nand2 u_binv (.y(b_inv), .a(b_q[0]), .b(b_q[0]));
  assign b_bit = sub_q ? b_inv : b_q[0];
`else
  assign b_bit = b_q[0];
`endif

  cmos_fa_slice u_slice (
    .a  (a_q[0]),
    .b  (b_bit),
    .c  (carry_q),
    .s  (s_bit),
    .co (c_bit)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef CMOS_SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q   <= a;
        b_q   <= b;
        cnt_q <= '0;
`ifdef CMOS_SERIAL_ADDER_SUB_EN
        sub_q   <= sub;
        carry_q <= sub ? 1'b1 : cin;
`else
        carry_q <= cin;
`endif
      end else if (state_q == SHIFT) begin
        // Sum fills from the MSB so that after WIDTH shifts bit 0 sits at sum_q[0].
        sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
        carry_q <= c_bit;
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_cmos_serial_adder.sv
// Randomised and directed bench for cmos_serial_adder against a cycle-count/arithmetic model.
// Honours CMOS_SERIAL_ADDER_SUB_EN when defined.

module tb_cmos_serial_adder;
  localparam int WIDTH = 8;
`ifdef CMOS_SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub_v = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  int vectors = 0;
  int errors  = 0;

  cmos_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef CMOS_SERIAL_ADDER_SUB_EN
    .sub   (sub_v),
`endif
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic c, input logic s);
    if (SUB_EN && s) return {1'b0, x} + {1'b0, ~y} + 1;
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // Model: phase 0 = idle, 1..WIDTH = bit cycles, WIDTH+1 = done cycle.
  int             m_phase = 0;
  logic [WIDTH:0] m_res = '0;
  bit             m_init = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_res   = '0;
      m_init  = 1'b1;
    end else if (start && (m_phase == 0 || m_phase == WIDTH + 1)) begin
      m_phase = 1;
      m_res   = ref_result(a, b, cin, sub_v);
    end else if (m_phase >= 1 && m_phase <= WIDTH) begin
      m_phase = m_phase + 1;
    end else if (m_phase == WIDTH + 1) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("busy", 65'(busy), 65'(m_phase >= 1 && m_phase <= WIDTH));
      check("done", 65'(done), 65'(m_phase == WIDTH + 1));
      if (m_phase == 0 || m_phase == WIDTH + 1)
        check("result", 65'({cout, sum}), 65'(m_res));
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 65'(done), 65'(1));
  endtask

  task automatic pulse_start(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                             input logic ic, input logic is);
    @(negedge clk);
    a = ia; b = ib; cin = ic; sub_v = is; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ic,
                    input logic is, input logic [WIDTH-1:0] es, input logic ec);
    int n;
    pulse_start(ia, ib, ic, is);
    a = ~ia; b = ~ib; cin = ~ic;
    wait_done(n);
    check("latency", 65'(n), 65'(WIDTH));
    check("lit_sum", 65'(sum), 65'(es));
    check("lit_cout", 65'(cout), 65'(ec));
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_sum", 65'({cout, sum}), 65'(0));
    check("rst_busy", 65'({busy, done}), 65'(0));

    op(8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
    repeat (2) @(negedge clk);
    check("hold_sum", 65'({cout, sum}), 65'(9'h001));

    // Start while busy must be ignored.
    pulse_start(8'h10, 8'h10, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ign_sum", 65'({cout, sum}), 65'(9'h020));

    // Reset mid-operation.
    repeat (2) @(negedge clk);
    pulse_start(8'hFF, 8'hFF, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ctl", 65'({busy, done}), 65'(0));
    check("midrst_res", 65'({cout, sum}), 65'(0));
    op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; sub_v = 1'b0; start = 1'b1;
    @(negedge clk);
    wait_done(n);
    check("b2b_sum0", 65'({cout, sum}), 65'(9'h010));
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      n = 1;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("b2b_period", 65'(n), 65'(WIDTH + 1));
      check("b2b_sum", 65'({cout, sum}), 65'(9'h010));
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

`ifdef CMOS_SERIAL_ADDER_SUB_EN
    op(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0);
    op(8'h20, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1);
    op(8'h20, 8'h10, 1'b1, 1'b0, 8'h31, 1'b0);
`endif

    // Random stream: inputs, start and occasional resets change every cycle.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      cin   = 1'($urandom);
      sub_v = 1'($urandom);
      start = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    repeat (WIDTH + 3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
